// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the single-port memory arbiter: FSM states,
// requester ids, fetch byte-enable and the latched backend request.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } arb_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic       REQ_D   = 1'b0;
  localparam logic       REQ_I   = 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision: data wins contention unless fetch has been starved
// for the configured number of consecutive data grants.
module mem_arb_prio
  import riscv_mem_pkg::*;
(
  input  logic d_pend,
  input  logic i_pend,
  input  logic starve_hit,
  output logic gnt,
  output logic gnt_id
);

  assign gnt    = d_pend | i_pend;
  assign gnt_id = (i_pend & (~d_pend | starve_hit)) ? REQ_I : REQ_D;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory between fetch and data ports with
// data priority, a fetch starvation guard and a per-access timeout.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_be,
  output logic [31:0] o_d_rdata,
  output logic        o_d_done,
  input  logic        i_i_req,
  input  logic [31:0] i_i_addr,
  output logic [31:0] o_i_rdata,
  output logic        o_i_done,
  output logic        o_stall_if,
  output logic        o_stall_mem,
  output logic        o_m_req,
  output logic        o_m_we,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  output logic [3:0]  o_m_be,
  input  logic        i_m_ack,
  input  logic [31:0] i_m_rdata,
  output logic        o_err
);

  arb_state_e  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic        m_req_q, m_req_d;
  logic [31:0] d_rdata_q, d_rdata_d, i_rdata_q, i_rdata_d;
  logic        d_done_q, d_done_d, i_done_q, i_done_d;
  logic        err_q, err_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  busy_q, busy_d;

  logic d_pend, i_pend, starve_hit, gnt, gnt_id, timed_out;

  // A port completing this cycle is not pending, so the other port can be
  // granted in the done cycle.
  assign d_pend     = i_d_req & ~d_done_q;
  assign i_pend     = i_i_req & ~i_done_q;
  assign starve_hit = (starve_q == 4'(STARVE_LIMIT));
  assign timed_out  = (busy_q == 8'(TIMEOUT_CYCLES - 1));

  mem_arb_prio u_prio (
    .d_pend     (d_pend),
    .i_pend     (i_pend),
    .starve_hit (starve_hit),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    m_req_d   = m_req_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    d_done_d  = 1'b0;
    i_done_d  = 1'b0;
    err_d     = err_q;
    starve_d  = starve_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          m_req_d = 1'b1;
          busy_d  = '0;
          if (gnt_id == REQ_I) begin
            req_d    = '{we: 1'b0, addr: i_i_addr, wdata: '0, be: BE_WORD};
            starve_d = '0;
            state_d  = BUSY_I;
          end else begin
            req_d   = '{we: i_d_we, addr: i_d_addr, wdata: i_d_wdata, be: i_d_be};
            state_d = BUSY_D;
            if (i_pend && !starve_hit) starve_d = starve_q + 4'd1;
          end
        end
      end
      BUSY_D, BUSY_I: begin
        busy_d = busy_q + 8'd1;
        // Ack takes precedence over a timeout landing in the same cycle.
        if (i_m_ack || timed_out) begin
          m_req_d = 1'b0;
          state_d = IDLE;
          err_d   = err_q | ~i_m_ack;
          if (state_q == BUSY_D) begin
            d_done_d  = 1'b1;
            d_rdata_d = i_m_ack ? i_m_rdata : '0;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = i_m_ack ? i_m_rdata : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      m_req_q   <= 1'b0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      d_done_q  <= 1'b0;
      i_done_q  <= 1'b0;
      err_q     <= 1'b0;
      starve_q  <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      m_req_q   <= m_req_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
      d_done_q  <= d_done_d;
      i_done_q  <= i_done_d;
      err_q     <= err_d;
      starve_q  <= starve_d;
      busy_q    <= busy_d;
    end
  end

  assign o_d_rdata   = d_rdata_q;
  assign o_d_done    = d_done_q;
  assign o_i_rdata   = i_rdata_q;
  assign o_i_done    = i_done_q;
  assign o_stall_if  = i_i_req & ~i_done_q;
  assign o_stall_mem = i_d_req & ~d_done_q;
  assign o_m_req     = m_req_q;
  assign o_m_we      = req_q.we;
  assign o_m_addr    = req_q.addr;
  assign o_m_wdata   = req_q.wdata;
  assign o_m_be      = req_q.be;
  assign o_err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants and completions are
// queued by the stimulus and popped by negedge monitors.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        i_d_req, i_d_we, i_i_req;
  logic [31:0] i_d_addr, i_d_wdata, i_i_addr;
  logic [3:0]  i_d_be;
  logic [31:0] o_d_rdata, o_i_rdata, o_m_addr, o_m_wdata, i_m_rdata;
  logic        o_d_done, o_i_done, o_stall_if, o_stall_mem;
  logic        o_m_req, o_m_we, i_m_ack, o_err;
  logic [3:0]  o_m_be;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_be(i_d_be),
    .o_d_rdata(o_d_rdata), .o_d_done(o_d_done),
    .i_i_req(i_i_req), .i_i_addr(i_i_addr),
    .o_i_rdata(o_i_rdata), .o_i_done(o_i_done),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem),
    .o_m_req(o_m_req), .o_m_we(o_m_we), .o_m_addr(o_m_addr),
    .o_m_wdata(o_m_wdata), .o_m_be(o_m_be),
    .i_m_ack(i_m_ack), .i_m_rdata(i_m_rdata), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } grant_t;

  grant_t      g_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] i_exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Backend: acks after ack_wait extra BUSY cycles, read data = addr + 3.
  logic        ack_en = 1'b1, auto_ack = 1'b0, force_ack = 1'b0;
  int          ack_wait = 0;
  logic [31:0] auto_rdata = '0, force_rdata = '0;
  assign i_m_ack   = auto_ack | force_ack;
  assign i_m_rdata = force_ack ? force_rdata : auto_rdata;

  initial begin
    int wcnt = 0;
    forever begin
      @(negedge clk);
      auto_ack = 1'b0;
      if (o_m_req && ack_en) begin
        if (wcnt == ack_wait) begin
          auto_ack   = 1'b1;
          auto_rdata = o_m_addr + 32'd3;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitors: grant order/content on each new o_m_req, rdata on each done.
  logic prev_mreq = 1'b0;
  always @(negedge clk) begin
    if (o_m_req && !prev_mreq) begin
      if (g_exp_q.size() == 0) chk("unexpected_grant", o_m_addr, 32'hFFFF_FFFF);
      else begin
        grant_t g;
        g = g_exp_q.pop_front();
        chk("grant_addr", o_m_addr, g.addr);
        chk("grant_we", {31'd0, o_m_we}, {31'd0, g.we});
        chk("grant_be", {28'd0, o_m_be}, {28'd0, g.be});
        if (g.we) chk("grant_wdata", o_m_wdata, g.wdata);
      end
    end
    prev_mreq = o_m_req;
    if (o_d_done) begin
      if (d_exp_q.size() == 0) chk("unexpected_d_done", o_d_rdata, 32'hFFFF_FFFF);
      else chk("d_rdata", o_d_rdata, d_exp_q.pop_front());
    end
    if (o_i_done) begin
      if (i_exp_q.size() == 0) chk("unexpected_i_done", o_i_rdata, 32'hFFFF_FFFF);
      else chk("i_rdata", o_i_rdata, i_exp_q.pop_front());
    end
  end

  task automatic push_g(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be);
    grant_t g;
    g = '{we: we, addr: a, wdata: wd, be: be};
    g_exp_q.push_back(g);
  endtask

  // Requesters: raise at a negedge, hold until done, drop in the done cycle.
  task automatic d_go(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp_rd);
    int n = 0;
    d_exp_q.push_back(exp_rd);
    i_d_req = 1'b1; i_d_we = we; i_d_addr = a; i_d_wdata = wd; i_d_be = be;
    do begin @(negedge clk); n++; end while (!o_d_done && n < 60);
    if (!o_d_done) chk("d_done_wait", 32'd0, 32'd1);
    i_d_req = 1'b0;
  endtask

  task automatic i_go(input logic [31:0] a, input logic [31:0] exp_rd);
    int n = 0;
    i_exp_q.push_back(exp_rd);
    i_i_req = 1'b1; i_i_addr = a;
    do begin @(negedge clk); n++; end while (!o_i_done && n < 60);
    if (!o_i_done) chk("i_done_wait", 32'd0, 32'd1);
    i_i_req = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    i_d_req = 0; i_d_we = 0; i_d_addr = 0; i_d_wdata = 0; i_d_be = 0;
    i_i_req = 0; i_i_addr = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_m_req", {31'd0, o_m_req}, 32'd0);
    chk("rst_m_addr", o_m_addr, 32'd0);
    chk("rst_m_be", {28'd0, o_m_be}, 32'd0);
    chk("rst_dones", {30'd0, o_d_done, o_i_done}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_rdata", o_d_rdata | o_i_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, zero-wait backend: grant at N+1, done at N+2.
    push_g(1'b0, 32'h10, 32'h0, 4'hF);
    i_exp_q.push_back(32'h13);
    i_i_req = 1'b1; i_i_addr = 32'h10;
    #1 chk("t1_stall_if_req", {31'd0, o_stall_if}, 32'd1);
    chk("t1_m_req_n", {31'd0, o_m_req}, 32'd0);
    @(negedge clk);
    chk("t1_m_req_n1", {31'd0, o_m_req}, 32'd1);
    chk("t1_stall_if_busy", {31'd0, o_stall_if}, 32'd1);
    @(negedge clk);
    chk("t1_i_done_n2", {31'd0, o_i_done}, 32'd1);
    chk("t1_stall_if_done", {31'd0, o_stall_if}, 32'd0);
    i_i_req = 1'b0;
    @(negedge clk);
    chk("t1_i_done_pulse", {31'd0, o_i_done}, 32'd0);
    @(negedge clk);

    // Simultaneous: data store first, fetch granted in the data done cycle.
    push_g(1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3);
    push_g(1'b0, 32'h200, 32'h0, 4'hF);
    fork
      d_go(1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3, 32'h103);
      i_go(32'h200, 32'h203);
      begin
        #1 chk("t2_stall_mem", {31'd0, o_stall_mem}, 32'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!o_d_done && n < 60);
        @(negedge clk);
        chk("t2_fetch_after_done", {31'd0, o_m_req}, 32'd1);
        chk("t2_fetch_addr", o_m_addr, 32'h200);
      end
    join
    @(negedge clk); @(negedge clk);

    // Sustained contention: grants alternate D,I,D,I,D.
    push_g(1'b0, 32'h300, 32'h0, 4'h0);
    push_g(1'b0, 32'h400, 32'h0, 4'hF);
    push_g(1'b0, 32'h304, 32'h0, 4'h1);
    push_g(1'b0, 32'h404, 32'h0, 4'hF);
    push_g(1'b0, 32'h308, 32'h0, 4'h2);
    fork
      begin
        d_go(1'b0, 32'h300, 32'h0, 4'h0, 32'h303);
        d_go(1'b0, 32'h304, 32'h0, 4'h1, 32'h307);
        d_go(1'b0, 32'h308, 32'h0, 4'h2, 32'h30B);
      end
      begin
        i_go(32'h400, 32'h403);
        i_go(32'h404, 32'h407);
      end
    join
    @(negedge clk);

    // Starvation guard: four contested data grants (fetch withdrawn each
    // time), then the fifth contest goes to fetch.
    pulse_rst();
    for (int k = 0; k < 4; k++) begin
      push_g(1'b0, 32'h500 + 32'(4 * k), 32'h0, 4'hF);
      fork
        d_go(1'b0, 32'h500 + 32'(4 * k), 32'h0, 4'hF, 32'h503 + 32'(4 * k));
        begin
          i_i_req = 1'b1; i_i_addr = 32'h600;
          @(negedge clk);
          i_i_req = 1'b0;
        end
      join
      @(negedge clk);
    end
    push_g(1'b0, 32'h600, 32'h0, 4'hF);
    push_g(1'b0, 32'h510, 32'h0, 4'hF);
    fork
      d_go(1'b0, 32'h510, 32'h0, 4'hF, 32'h513);
      i_go(32'h600, 32'h603);
    join
    @(negedge clk);

    // Ack in the 8th BUSY cycle beats the timeout.
    ack_wait = 7;
    push_g(1'b0, 32'h700, 32'h0, 4'hF);
    d_go(1'b0, 32'h700, 32'h0, 4'hF, 32'h703);
    chk("t5_err_clear", {31'd0, o_err}, 32'd0);
    @(negedge clk);

    // Timeout: no ack, o_m_req held exactly 8 cycles, done with rdata 0.
    ack_en = 1'b0; ack_wait = 0;
    push_g(1'b0, 32'h800, 32'h0, 4'hF);
    d_exp_q.push_back(32'h0);
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h800; i_d_be = 4'hF;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_d_done) break;
      if (o_m_req) n++;
    end
    chk("t6_busy_cycles", 32'(n), 32'd8);
    chk("t6_done", {31'd0, o_d_done}, 32'd1);
    chk("t6_err_set", {31'd0, o_err}, 32'd1);
    chk("t6_stall_mem_done", {31'd0, o_stall_mem}, 32'd0);
    i_d_req = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    push_g(1'b0, 32'h900, 32'h0, 4'hF);
    i_go(32'h900, 32'h903);
    chk("t6_err_sticky", {31'd0, o_err}, 32'd1);
    @(negedge clk);

    // Reset mid-access in BUSY_I; a late ack must be ignored.
    ack_en = 1'b0;
    push_g(1'b0, 32'hA00, 32'h0, 4'hF);
    i_i_req = 1'b1; i_i_addr = 32'hA00;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; i_i_req = 1'b0;
    #1 chk("t7_m_req_async", {31'd0, o_m_req}, 32'd0);
    chk("t7_err_clear", {31'd0, o_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    force_rdata = 32'hBAD0_BAD0; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t7_no_done", {30'd0, o_d_done, o_i_done}, 32'd0);
      chk("t7_m_req_idle", {31'd0, o_m_req}, 32'd0);
      @(negedge clk);
    end
    ack_en = 1'b1;
    push_g(1'b0, 32'hB00, 32'h0, 4'hF);
    i_go(32'hB00, 32'hB03);
    @(negedge clk); @(negedge clk);

    chk("grant_q_drained", 32'(g_exp_q.size()), 32'd0);
    chk("d_q_drained", 32'(d_exp_q.size()), 32'd0);
    chk("i_q_drained", 32'(i_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
